// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC scheduler: FSM states, the delay-line tag and
// the request-to-result latency helper.
package cordic_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} sched_state_t;

  // Tag index is sized for the largest supported requester count (16).
  localparam int TAG_IW = 4;

  typedef struct packed {
    logic              valid;
    logic [TAG_IW-1:0] idx;
  } tag_t;

  function automatic int latency(input int iterations);
    return iterations + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping) and reports the pointer value that follows that grant.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] next_ptr
);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    k        = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        next_ptr = IW'((int'(ptr) + i + 1) % N);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one pipelined CORDIC core between N_REQ
// requesters. Define CORDIC_SCHED_STATS_EN to add per-requester issue counters.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = WIDTH + 2,
  parameter int N_REQ      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_x0,
  input  logic [N_REQ*WIDTH-1:0]     req_y0,
  input  logic [N_REQ*WIDTH-1:0]     req_z0,
  output logic [WIDTH-1:0]           cor_x0,
  output logic [WIDTH-1:0]           cor_y0,
  output logic [WIDTH-1:0]           cor_z0,
  input  logic [WIDTH:0]             cor_x,
  input  logic [WIDTH:0]             cor_y,
  input  logic [WIDTH-1:0]           cor_z,
  output logic [N_REQ-1:0]           res_valid,
  output logic [WIDTH:0]             res_x,
  output logic [WIDTH:0]             res_y,
  output logic [WIDTH-1:0]           res_z,
  input  logic                       halt,
  output logic                       idle,
`ifdef CORDIC_SCHED_STATS_EN
  output logic [N_REQ*32-1:0]        issue_cnt,
`endif
  output sched_state_t               dbg_state,
  output logic [$clog2(N_REQ)-1:0]   dbg_ptr
);

  localparam int IW    = $clog2(N_REQ);
  // One stage per core iteration plus one for the core's output register.
  localparam int DEPTH = latency(ITERATIONS);

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    next_ptr;
  logic [IW-1:0]    grant_idx;
  logic             issue_en;
  logic             xfer;
  logic             dly_any;
  tag_t             dly [DEPTH];

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (dbg_ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  // Handshake: requester k transfers on an edge where req_valid[k] & req_ready[k];
  // it must hold valid and operands until then. Ready is one-hot or zero and is
  // withheld during reset, in DRAIN/HALTED, and in the cycle halt is first seen.
  assign issue_en  = reset_n && (dbg_state == RUN) && !halt;
  assign req_ready = issue_en ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    cor_x0    = '0;
    cor_y0    = '0;
    cor_z0    = '0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_ready[k]) begin
        cor_x0    = req_x0[k*WIDTH +: WIDTH];
        cor_y0    = req_y0[k*WIDTH +: WIDTH];
        cor_z0    = req_z0[k*WIDTH +: WIDTH];
        grant_idx = IW'(k);
      end
    end
  end

  always_comb begin
    dly_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) dly_any = dly_any | dly[i].valid;
  end

  assign idle = !dly_any && !(|res_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbg_ptr   <= '0;
      res_valid <= '0;
      res_x     <= '0;
      res_y     <= '0;
      res_z     <= '0;
      for (int i = 0; i < DEPTH; i++) dly[i] <= '0;
    end else begin
      if (xfer) dbg_ptr <= next_ptr;
      dly[0] <= '{valid: xfer, idx: TAG_IW'(grant_idx)};
      for (int i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
      res_valid <= dly[DEPTH-1].valid ? (N_REQ'(1) << dly[DEPTH-1].idx) : '0;
      // Result data only moves with a valid tag so the last result stays visible.
      if (dly[DEPTH-1].valid) begin
        res_x <= cor_x;
        res_y <= cor_y;
        res_z <= cor_z;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbg_state <= RUN;
    end else begin
      case (dbg_state)
        RUN:     if (halt) dbg_state <= DRAIN;
        DRAIN:   if (!halt) dbg_state <= RUN;
                 else if (!dly_any && !(|res_valid)) dbg_state <= HALTED;
        HALTED:  if (!halt) dbg_state <= RUN;
        default: dbg_state <= RUN;
      endcase
    end
  end

`ifdef CORDIC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++)
        if (req_ready[k]) issue_cnt[k*32 +: 32] <= issue_cnt[k*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule
